// File: rtl/timer_periph.sv
`timescale 1ns/1ps
// Purpose: memory-mapped interval timer on the CPU I/O bus; optional PWM output when TIMER_PWM_EN is defined.
// Latency: reads are combinational in the access cycle; writes commit on the closing clk edge; irq_code pulses the cycle after expiry.
// Backpressure: none; every access completes in its single bus cycle and the timer never stalls the CPU.
module timer_periph #(
    parameter logic [15:0] BASE_ADDR = 16'h0080,
    parameter logic [2:0]  IRQ_CODE  = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_wishbone,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] dir,
    input  logic [7:0]  dato_in,
    output logic [7:0]  dato_out,
    output logic [2:0]  irq_code
`ifdef TIMER_PWM_EN
    ,
    output logic        pwm_out
`endif
);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRESC  = 3'd1;
    localparam logic [2:0] OFF_RELOAD = 3'd2;
    localparam logic [2:0] OFF_COUNT  = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;
    localparam logic [2:0] OFF_CMP    = 3'd5;

    logic       sel, wr_stb, rd_en, ctrl_wr;
    logic [2:0] off;
    logic       tick, expire;

    logic       run_q, run_d;
    logic       irq_en_q, irq_en_d;
    logic       oneshot_q, oneshot_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] reload_q, reload_d;
    logic [7:0] count_q, count_d;
    logic [7:0] pcnt_q, pcnt_d;
    logic       exp_q, exp_d;
    logic       ovr_q, ovr_d;
    logic [2:0] irq_q, irq_d;
`ifdef TIMER_PWM_EN
    logic [7:0] cmp_q, cmp_d;
    logic       pwm_q, pwm_d;
`endif

    assign sel     = enable_wishbone && (dir[15:3] == BASE_ADDR[15:3]);
    assign wr_stb  = sel && wr;
    assign rd_en   = sel && rd;
    assign off     = dir[2:0];
    assign ctrl_wr = wr_stb && (off == OFF_CTRL);

    // Next-state: CPU writes first, then prescaler/counter; a CTRL write freezes the timer for that cycle.
    always_comb begin
        run_d     = run_q;
        irq_en_d  = irq_en_q;
        oneshot_d = oneshot_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        count_d   = count_q;
        pcnt_d    = pcnt_q;
        exp_d     = exp_q;
        ovr_d     = ovr_q;
        irq_d     = 3'b000;
        tick      = 1'b0;
        expire    = 1'b0;
`ifdef TIMER_PWM_EN
        cmp_d     = cmp_q;
`endif
        if (wr_stb) begin
            case (off)
                OFF_CTRL: begin
                    run_d     = dato_in[0];
                    irq_en_d  = dato_in[1];
                    oneshot_d = dato_in[2];
                    if (dato_in[3]) begin
                        count_d = reload_q;
                        pcnt_d  = 8'd0;
                    end
                end
                OFF_PRESC:  presc_d  = dato_in;
                OFF_RELOAD: reload_d = dato_in;
                OFF_STATUS: begin
                    if (dato_in[0]) exp_d = 1'b0;
                    if (dato_in[1]) ovr_d = 1'b0;
                end
`ifdef TIMER_PWM_EN
                OFF_CMP:    cmp_d = dato_in;
`endif
                default: ;
            endcase
        end
        // Prescaler only advances while running and not overridden by a CTRL write.
        if (run_q && !ctrl_wr) begin
            if (pcnt_q == presc_q) begin
                pcnt_d = 8'd0;
                tick   = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
        end
        if (tick) begin
            if (count_q == 8'd0) begin
                expire  = 1'b1;
                count_d = reload_q;
            end else begin
                count_d = count_q - 8'd1;
            end
        end
        // Expiry sets beat a same-cycle W1C; OVR looks at the pre-clear EXP.
        if (expire) begin
            exp_d = 1'b1;
            if (exp_q)     ovr_d = 1'b1;
            if (irq_en_q)  irq_d = IRQ_CODE;
            if (oneshot_q) run_d = 1'b0;
        end
`ifdef TIMER_PWM_EN
        pwm_d = run_q && (count_q < cmp_q);
`endif
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            oneshot_q <= 1'b0;
            presc_q   <= 8'd0;
            reload_q  <= 8'd0;
            count_q   <= 8'd0;
            pcnt_q    <= 8'd0;
            exp_q     <= 1'b0;
            ovr_q     <= 1'b0;
            irq_q     <= 3'b000;
`ifdef TIMER_PWM_EN
            cmp_q     <= 8'd0;
            pwm_q     <= 1'b0;
`endif
        end else begin
            run_q     <= run_d;
            irq_en_q  <= irq_en_d;
            oneshot_q <= oneshot_d;
            presc_q   <= presc_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            pcnt_q    <= pcnt_d;
            exp_q     <= exp_d;
            ovr_q     <= ovr_d;
            irq_q     <= irq_d;
`ifdef TIMER_PWM_EN
            cmp_q     <= cmp_d;
            pwm_q     <= pwm_d;
`endif
        end
    end

    // Read mux drives zero when not selected so several peripherals can be ORed onto one bus.
    always_comb begin
        dato_out = 8'h00;
        if (rd_en) begin
            case (off)
                OFF_CTRL:   dato_out = {5'b0, oneshot_q, irq_en_q, run_q};
                OFF_PRESC:  dato_out = presc_q;
                OFF_RELOAD: dato_out = reload_q;
                OFF_COUNT:  dato_out = count_q;
                OFF_STATUS: dato_out = {6'b0, ovr_q, exp_q};
`ifdef TIMER_PWM_EN
                OFF_CMP:    dato_out = cmp_q;
`endif
                default:    dato_out = 8'h00;
            endcase
        end
    end

    assign irq_code = irq_q;
`ifdef TIMER_PWM_EN
    assign pwm_out  = pwm_q;
`endif

endmodule

// File: tb/tb_timer_periph.sv
`timescale 1ns/1ps
// Scoreboard bench for timer_periph: read and irq expectations are queued by stimulus, checked by a monitor.
module tb_timer_periph;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_wishbone = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] dir = 16'h0000;
    logic [7:0]  dato_in = 8'h00;
    logic [7:0]  dato_out;
    logic [2:0]  irq_code;
`ifdef TIMER_PWM_EN
    logic        pwm_out;
`endif

    timer_periph #(.BASE_ADDR(16'h0080), .IRQ_CODE(3'b001)) dut (
        .clk(clk),
        .reset(reset),
        .enable_wishbone(enable_wishbone),
        .rd(rd),
        .wr(wr),
        .dir(dir),
        .dato_in(dato_in),
        .dato_out(dato_out),
        .irq_code(irq_code)
`ifdef TIMER_PWM_EN
        ,
        .pwm_out(pwm_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      irq_q[$];
    int      cyc = 0;
    int      n_cmp = 0;
    int      n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every bus read and every irq cycle against the queued expectations.
    always @(negedge clk) begin
        if (!reset) begin
            if (enable_wishbone && rd) begin
                n_cmp++;
                if (rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: dato_out=%h with no expectation queued", dato_out);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    if (dato_out !== e.exp) begin
                        n_err++;
                        $display("FAIL %s: got %h, want %h (cyc %0d)", e.name, dato_out, e.exp, cyc);
                    end
                end
            end
            if (irq_q.size() > 0 && irq_q[0] == cyc) begin
                void'(irq_q.pop_front());
                n_cmp++;
                if (irq_code !== 3'b001) begin
                    n_err++;
                    $display("FAIL irq_pulse: got %b, want 001 (cyc %0d)", irq_code, cyc);
                end
            end else if (irq_code !== 3'b000) begin
                n_cmp++;
                n_err++;
                $display("FAIL irq_unexpected: got %b, want 000 (cyc %0d)", irq_code, cyc);
            end
        end
    end

    task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
        dir = 16'h0080 + {13'b0, off};
        dato_in = d;
        wr = 1'b1;
        rd = 1'b0;
        enable_wishbone = 1'b1;
        @(posedge clk);
        #1;
        enable_wishbone = 1'b0;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [7:0] e, input string nm);
        rd_exp_t x;
        x.name = nm;
        x.exp = e;
        rd_q.push_back(x);
        dir = a;
        wr = 1'b0;
        rd = 1'b1;
        enable_wishbone = 1'b1;
        @(posedge clk);
        #1;
        enable_wishbone = 1'b0;
        rd = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: whole window and an unselected address read zero.
        for (int i = 0; i < 8; i++) begin
            bus_rd(16'h0080 + 16'(i), 8'h00, $sformatf("reset_off%0d", i));
        end
        bus_rd(16'h0090, 8'h00, "unselected_addr");

        // Periodic run: PRESC=1, RELOAD=3 -> expiry every 8 cycles.
        bus_wr(3'd1, 8'd1);
        bus_wr(3'd2, 8'd3);
        bus_wr(3'd0, 8'h0B);
        c0 = cyc;
        irq_q.push_back(c0 + 8);
        irq_q.push_back(c0 + 16);
        irq_q.push_back(c0 + 24);
        bus_rd(16'h0083, 8'd3, "count_after_load");
        bus_rd(16'h0080, 8'h03, "ctrl_readback_load_is_0");
        wait_until(c0 + 9);
        bus_rd(16'h0084, 8'h01, "status_first_exp");
        bus_rd(16'h0083, 8'd2, "count_after_reload");
        wait_until(c0 + 17);
        bus_rd(16'h0084, 8'h03, "status_ovr");
        bus_wr(3'd4, 8'h03);
        bus_rd(16'h0084, 8'h00, "status_w1c");
        wait_until(c0 + 23);
        bus_wr(3'd4, 8'h01);
        bus_rd(16'h0084, 8'h01, "status_set_beats_clear");
        bus_wr(3'd0, 8'h00);
        bus_wr(3'd4, 8'h03);
        bus_rd(16'h0083, 8'd3, "count_frozen_after_stop");

        // One-shot: RELOAD=2, PRESC=0 -> single pulse 3 cycles after start.
        bus_wr(3'd2, 8'd2);
        bus_wr(3'd1, 8'd0);
        bus_wr(3'd0, 8'h0F);
        c1 = cyc;
        irq_q.push_back(c1 + 3);
        wait_until(c1 + 5);
        bus_rd(16'h0080, 8'h06, "oneshot_ctrl");
        bus_rd(16'h0083, 8'd2, "oneshot_count");
        bus_rd(16'h0084, 8'h01, "oneshot_status");
        wait_until(c1 + 25);
        bus_wr(3'd4, 8'h03);

        // IRQ disabled, COUNT write ignored, CTRL write suppresses a tick.
        bus_wr(3'd2, 8'd5);
        bus_wr(3'd0, 8'h09);
        c2 = cyc;
        wait_until(c2 + 7);
        bus_rd(16'h0084, 8'h01, "noirq_status_exp");
        bus_wr(3'd3, 8'h55);
        bus_rd(16'h0083, 8'd2, "count_write_ignored");
        bus_wr(3'd0, 8'h00);
        bus_rd(16'h0083, 8'd1, "ctrl_write_suppresses_tick");
        wait_until(c2 + 16);
        bus_rd(16'h0083, 8'd1, "count_stays_frozen");
        bus_rd(16'h0080, 8'h00, "ctrl_stopped");

`ifdef TIMER_PWM_EN
        begin
            int hi;
            bus_wr(3'd2, 8'd9);
            bus_wr(3'd5, 8'd3);
            bus_rd(16'h0085, 8'd3, "cmp_readback");
            bus_wr(3'd0, 8'h09);
            wait_until(cyc + 12);
            hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (pwm_out) hi++;
            end
            n_cmp++;
            if (hi != 6) begin
                n_err++;
                $display("FAIL pwm_duty: got %0d high of 20, want 6", hi);
            end
            @(posedge clk);
            #1;
            bus_wr(3'd5, 8'd0);
            hi = 0;
            repeat (20) begin
                @(negedge clk);
                if (pwm_out) hi++;
            end
            n_cmp++;
            if (hi != 0) begin
                n_err++;
                $display("FAIL pwm_cmp0: got %0d high of 20, want 0", hi);
            end
            @(posedge clk);
            #1;
            bus_wr(3'd0, 8'h00);
            bus_wr(3'd4, 8'h03);
        end
`endif

        // Reset mid-count: no event, everything back to zero.
        bus_wr(3'd1, 8'd0);
        bus_wr(3'd2, 8'd200);
        bus_wr(3'd0, 8'h0B);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_rd(16'h0080 + 16'(i), 8'h00, $sformatf("midreset_off%0d", i));
        end
        repeat (10) @(posedge clk);
        #1;
        bus_rd(16'h0083, 8'h00, "midreset_count_idle");

        repeat (2) @(posedge clk);
        #1;
        if (rd_q.size() != 0 || irq_q.size() != 0) begin
            n_err += rd_q.size() + irq_q.size();
            $display("FAIL scoreboard_drain: %0d reads and %0d irq pulses still expected, want 0", rd_q.size(), irq_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
